// File: rtl/ray_pkg.sv
// Shared types for the ray/AABB stepper: result status, axis encoding and FSM states.
package ray_pkg;

  typedef enum logic [1:0] {
    EXIT    = 2'd0,
    OOB     = 2'd1,
    TIMEOUT = 2'd2,
    INVALID = 2'd3
  } status_t;

  typedef logic [1:0] axis_t;
  localparam axis_t AXIS_NONE = 2'd3;

  // Default-width three-axis bundle for neighbouring stages that do not re-parametrise.
  localparam int unsigned VEC3_W = 16;
  typedef logic [2:0][VEC3_W-1:0] vec3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ray_axis_eval.sv
// One axis of a stepper iteration: rounded proposal, box/face tests, clamp and halved step.
module ray_axis_eval #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SCALE = 0
) (
  input  logic signed [WIDTH+SCALE+2:0] acc_i,
  input  logic signed [WIDTH+SCALE+1:0] step_i,
  input  logic        [WIDTH-1:0]       l_i,
  input  logic        [WIDTH-1:0]       u_i,
  output logic signed [WIDTH+SCALE+2:0] p_o,
  output logic                          in_o,
  output logic                          on_o,
  output logic                          upper_o,
  output logic                          oor_o,
  output logic        [WIDTH-1:0]       clamp_o,
  output logic signed [WIDTH+SCALE+1:0] step_half_o
);
  localparam int unsigned SW = WIDTH + SCALE + 2;
  localparam int unsigned EW = WIDTH + SCALE + 3;

  logic signed [SW-1:0] rounded;
  logic signed [EW-1:0] lo;
  logic signed [EW-1:0] hi;
  logic                 above_max;

  always_comb begin
    // step carries one fractional bit; positive halves round up, negative ones floor
    rounded = step_i >>> 1;
    if (!step_i[SW-1] && step_i[0]) begin
      rounded = rounded + SW'(1);
    end
    p_o = acc_i + {{(EW-SW){rounded[SW-1]}}, rounded};

    lo = {{(EW-WIDTH){1'b0}}, l_i} - EW'(1);
    hi = {{(EW-WIDTH){1'b0}}, u_i} + EW'(1);

    in_o    = (p_o >= lo) && (p_o <= hi);
    on_o    = (p_o == lo) || (p_o == hi);
    upper_o = (p_o == hi);

    above_max = |p_o[EW-2:WIDTH];
    oor_o     = p_o[EW-1] || above_max;
    if (p_o[EW-1]) begin
      clamp_o = '0;
    end else if (above_max) begin
      clamp_o = '1;
    end else begin
      clamp_o = p_o[WIDTH-1:0];
    end

    step_half_o = step_i >>> 1;
  end

endmodule

// File: rtl/ray_aabb_stepper.sv
// Handshaked ray stepper: halving search for the first integer position one unit outside an AABB.
module ray_aabb_stepper
  import ray_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SCALE    = 0,
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*WIDTH-1:0]   q,
  input  logic [3*WIDTH-1:0]   v,
  input  logic [3*WIDTH-1:0]   l,
  input  logic [3*WIDTH-1:0]   u,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*WIDTH-1:0]   qp,
  output logic [1:0]           status,
  output logic [1:0]           exit_axis,
  output logic                 exit_upper,
  output logic [ITER_W-1:0]    iters
);
  localparam int unsigned SW = WIDTH + SCALE + 2;
  localparam int unsigned EW = WIDTH + SCALE + 3;

  state_t               state_q, state_d;
  logic                 first_q, first_d;
  logic [ITER_W-1:0]    iter_q, iter_d, iter_inc;
  logic [WIDTH-1:0]     l_q [3];
  logic [WIDTH-1:0]     l_d [3];
  logic [WIDTH-1:0]     u_q [3];
  logic [WIDTH-1:0]     u_d [3];
  logic signed [EW-1:0] acc_q [3];
  logic signed [EW-1:0] acc_d [3];
  logic signed [EW-1:0] p [3];
  logic signed [SW-1:0] step_q [3];
  logic signed [SW-1:0] step_d [3];
  logic signed [SW-1:0] step_half [3];
  logic [WIDTH-1:0]     clamp [3];
  logic [2:0]           in_box, on_face, face_upper, oor;

  logic [3*WIDTH-1:0]   qp_q, qp_d;
  status_t              status_q, status_d;
  axis_t                axis_q, axis_d;
  logic                 upper_q, upper_d;
  logic [ITER_W-1:0]    iters_q, iters_d;

  logic                 invalid_start, step_hold, hit_found;

  for (genvar g = 0; g < 3; g++) begin : g_axis
    ray_axis_eval #(
      .WIDTH (WIDTH),
      .SCALE (SCALE)
    ) u_axis (
      .acc_i       (acc_q[g]),
      .step_i      (step_q[g]),
      .l_i         (l_q[g]),
      .u_i         (u_q[g]),
      .p_o         (p[g]),
      .in_o        (in_box[g]),
      .on_o        (on_face[g]),
      .upper_o     (face_upper[g]),
      .oor_o       (oor[g]),
      .clamp_o     (clamp[g]),
      .step_half_o (step_half[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    iter_d   = iter_q;
    l_d      = l_q;
    u_d      = u_q;
    acc_d    = acc_q;
    step_d   = step_q;
    qp_d     = qp_q;
    status_d = status_q;
    axis_d   = axis_q;
    upper_d  = upper_q;
    iters_d  = iters_q;

    iter_inc = iter_q + ITER_W'(1);

    // acc still holds the latched start point during the first STEP cycle
    invalid_start = 1'b0;
    step_hold     = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      if (acc_q[i][WIDTH-1:0] < l_q[i] || acc_q[i][WIDTH-1:0] > u_q[i]) begin
        invalid_start = 1'b1;
      end
      if (step_half[i] != '0) begin
        step_hold = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = STEP;
          first_d = 1'b1;
          iter_d  = '0;
          for (int unsigned i = 0; i < 3; i++) begin
            l_d[i]    = l[i*WIDTH +: WIDTH];
            u_d[i]    = u[i*WIDTH +: WIDTH];
            acc_d[i]  = {{(EW-WIDTH){1'b0}}, q[i*WIDTH +: WIDTH]};
            step_d[i] = {{(SW-WIDTH){v[i*WIDTH+WIDTH-1]}}, v[i*WIDTH +: WIDTH]} << (SCALE + 1);
          end
        end
      end

      STEP: begin
        first_d = 1'b0;
        if (first_q && invalid_start) begin
          state_d  = RESP;
          status_d = INVALID;
          axis_d   = AXIS_NONE;
          upper_d  = 1'b0;
          iters_d  = '0;
          for (int unsigned i = 0; i < 3; i++) begin
            qp_d[i*WIDTH +: WIDTH] = acc_q[i][WIDTH-1:0];
          end
        end else begin
          iter_d = iter_inc;
          if (&in_box) begin
            acc_d = p;
          end
          if (!step_hold) begin
            step_d = step_half;
          end
          if (|on_face) begin
            state_d   = RESP;
            status_d  = (|oor) ? OOB : EXIT;
            iters_d   = iter_inc;
            hit_found = 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
              qp_d[i*WIDTH +: WIDTH] = clamp[i];
              if (on_face[i] && !hit_found) begin
                hit_found = 1'b1;
                axis_d    = axis_t'(i);
                upper_d   = face_upper[i];
              end
            end
          end else if (iter_inc == ITER_W'(MAX_ITER)) begin
            state_d  = RESP;
            status_d = TIMEOUT;
            axis_d   = AXIS_NONE;
            upper_d  = 1'b0;
            iters_d  = iter_inc;
            for (int unsigned i = 0; i < 3; i++) begin
              qp_d[i*WIDTH +: WIDTH] = acc_d[i][WIDTH-1:0];
            end
          end
        end
      end

      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      first_q  <= 1'b0;
      iter_q   <= '0;
      qp_q     <= '0;
      status_q <= EXIT;
      axis_q   <= AXIS_NONE;
      upper_q  <= 1'b0;
      iters_q  <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        l_q[i]    <= '0;
        u_q[i]    <= '0;
        acc_q[i]  <= '0;
        step_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      iter_q   <= iter_d;
      qp_q     <= qp_d;
      status_q <= status_d;
      axis_q   <= axis_d;
      upper_q  <= upper_d;
      iters_q  <= iters_d;
      l_q      <= l_d;
      u_q      <= u_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == RESP);
  assign qp         = qp_q;
  assign status     = status_q;
  assign exit_axis  = axis_q;
  assign exit_upper = upper_q;
  assign iters      = iters_q;

endmodule
